// File: rtl/alu_share_arb_pkg.sv
// Shared definitions for the two-port ALU sharing arbiter.
// Holds the ALU op-code encodings, the sequencer state encoding and
// the helper that computes how many extra EXEC cycles an op needs.
package alu_share_arb_pkg;

   // ALU control codes; 3'b111 is unassigned and yields a zero result
   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_XOR = 3'b011;
   localparam logic [2:0] ALU_SLL = 3'b100;
   localparam logic [2:0] ALU_SRA = 3'b101;
   localparam logic [2:0] ALU_MUL = 3'b110;

   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_EXEC = 2'd1,
      ARB_RESP = 2'd2
   } arb_state_t;

   // Value loaded into the EXEC down-counter at accept: multiply stays
   // in EXEC for mul_lat cycles, everything else for a single cycle.
   function automatic logic [3:0] cnt_load(input logic [2:0] op, input int unsigned mul_lat);
      if (op == ALU_MUL) begin
         return 4'(mul_lat - 1);
      end
      return 4'd0;
   endfunction

endpackage

// File: rtl/alu.sv
// Single-cycle 32-bit ALU datapath shared by both requesters.
// Latency: combinational; multiply is given a multi-cycle window by the caller.
// Backpressure: none; operands must be held stable by the caller.
module alu
   import alu_share_arb_pkg::*;
(
   input  logic [2:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] result
);

   // Decode the op; shift amounts of 32 or more saturate instead of wrapping
   always_comb begin
      result = 32'h0;
      case (op)
         ALU_ADD: result = a + b;
         ALU_SUB: result = a - b;
         ALU_AND: result = a & b;
         ALU_XOR: result = a ^ b;
         ALU_SLL: result = (b[31:5] != 27'd0) ? 32'h0 : (a << b[4:0]);
         ALU_SRA: result = (b[31:5] != 27'd0) ? {32{a[31]}} : 32'($signed(a) >>> b[4:0]);
         ALU_MUL: result = a * b;
         default: result = 32'h0;
      endcase
   end

endmodule

// File: rtl/rr_arb2.sv
// Two-way round-robin grant, purely combinational.
// Latency: zero cycles (grant follows valid/last in the same cycle).
// Backpressure: none; the caller decides when the grant is consumed.
module rr_arb2 (
   input  logic [1:0] valid,
   input  logic       last,
   output logic       grant,
   output logic       any
);

   // A lone requester always wins; on contention the port that did not win last time goes
   always_comb begin
      any   = |valid;
      grant = 1'b0;
      if (valid == 2'b11) begin
         grant = ~last;
      end else if (valid[1]) begin
         grant = 1'b1;
      end
   end

endmodule

// File: rtl/alu_share_arb.sv
// Shares one ALU between two requesters with round-robin arbitration.
// Latency: response 2 cycles after accept (MUL_LAT+1 for multiply).
// Backpressure: holds the response until rsp_ready_i; no accepts while busy.
module alu_share_arb
   import alu_share_arb_pkg::*;
#(
   parameter int unsigned MUL_LAT = 3
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req0_valid_i,
   output logic        req0_ready_o,
   input  logic [2:0]  req0_op_i,
   input  logic [31:0] req0_a_i,
   input  logic [31:0] req0_b_i,
   input  logic        req1_valid_i,
   output logic        req1_ready_o,
   input  logic [2:0]  req1_op_i,
   input  logic [31:0] req1_a_i,
   input  logic [31:0] req1_b_i,
   output logic        rsp_valid_o,
   input  logic        rsp_ready_i,
   output logic        rsp_id_o,
   output logic [31:0] rsp_data_o,
   output logic        rsp_zero_o
);

   arb_state_t  state_q;
   logic [2:0]  op_q;
   logic [31:0] a_q;
   logic [31:0] b_q;
   logic        id_q;
   logic        last_q;
   logic [3:0]  cnt_q;
   logic [31:0] res_q;
   logic        rsp_valid_q;

   logic        grant;
   logic        any_vld;
   logic        idle;
   logic [2:0]  sel_op;
   logic [31:0] sel_a;
   logic [31:0] sel_b;
   logic [31:0] alu_res;

   rr_arb2 u_arb (
      .valid ({req1_valid_i, req0_valid_i}),
      .last  (last_q),
      .grant (grant),
      .any   (any_vld)
   );

   // The ALU only ever sees the operand registers, so it is stable for the whole EXEC window
   alu u_alu (
      .op     (op_q),
      .a      (a_q),
      .b      (b_q),
      .result (alu_res)
   );

   // Readies are only offered in IDLE and only to the granted port; payload mux follows the grant
   always_comb begin
      idle         = (state_q == ARB_IDLE);
      req0_ready_o = idle && any_vld && !grant;
      req1_ready_o = idle && any_vld && grant;
      sel_op       = grant ? req1_op_i : req0_op_i;
      sel_a        = grant ? req1_a_i  : req0_a_i;
      sel_b        = grant ? req1_b_i  : req0_b_i;
   end

   // Sequencer: accept in IDLE, count down in EXEC, hold the registered result in RESP
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= ARB_IDLE;
         op_q        <= ALU_ADD;
         a_q         <= 32'h0;
         b_q         <= 32'h0;
         id_q        <= 1'b0;
         last_q      <= 1'b1;
         cnt_q       <= 4'd0;
         res_q       <= 32'h0;
         rsp_valid_q <= 1'b0;
      end else begin
         case (state_q)
            ARB_IDLE: begin
               if (any_vld) begin
                  op_q    <= sel_op;
                  a_q     <= sel_a;
                  b_q     <= sel_b;
                  id_q    <= grant;
                  last_q  <= grant;
                  cnt_q   <= cnt_load(sel_op, MUL_LAT);
                  state_q <= ARB_EXEC;
               end
            end
            ARB_EXEC: begin
               if (cnt_q != 4'd0) begin
                  cnt_q <= cnt_q - 4'd1;
               end else begin
                  res_q       <= alu_res;
                  rsp_valid_q <= 1'b1;
                  state_q     <= ARB_RESP;
               end
            end
            ARB_RESP: begin
               if (rsp_ready_i) begin
                  rsp_valid_q <= 1'b0;
                  state_q     <= ARB_IDLE;
               end
            end
            default: begin
               rsp_valid_q <= 1'b0;
               state_q     <= ARB_IDLE;
            end
         endcase
      end
   end

   // Zero flag comes from the held result and is suppressed while no response is offered
   always_comb begin
      rsp_valid_o = rsp_valid_q;
      rsp_data_o  = res_q;
      rsp_id_o    = id_q;
      rsp_zero_o  = rsp_valid_q && (res_q == 32'h0);
   end

endmodule

// File: doc/alu_share_arb.md
# alu_share_arb

Two-port arbiter and sequencer that shares one ALU datapath between two requesters, e.g. the execute stage and a multi-cycle address or immediate helper. It accepts one operation at a time through a valid/ready handshake and picks between simultaneous requests by round-robin. It holds the operands stable while the ALU evaluates, including a configurable multi-cycle window for multiply. It returns a registered result, tagged with the requester ID, through a valid/ready response channel.

## Interface
- `MUL_LAT`, 3: number of EXEC cycles for `ALU_MUL`. Legal range 1..15.
- `clk_i` input 1: single clock. Every register updates on its rising edge.
- `rst_i` input 1: reset. Asynchronous and active-high.
- `req0_valid_i` / `req1_valid_i` input 1: request present on port 0 / port 1.
- `req0_ready_o` / `req1_ready_o` output 1: request accepted this cycle.
- `req0_op_i` / `req1_op_i` input 3: ALU control code. Uses the shared `ALU_*` encodings.
- `req0_a_i`, `req0_b_i` / `req1_a_i`, `req1_b_i` input 32: operands.
- `rsp_valid_o` output 1: result available.
- `rsp_ready_i` input 1: consumer takes the result.
- `rsp_id_o` output 1: port that issued the result.
- `rsp_data_o` output 32: ALU result.
- `rsp_zero_o` output 1: high when `rsp_data_o` is 0.

## Operation
- **FSM states:** IDLE, EXEC, RESP. Reset state is IDLE.
- **IDLE, ready generation:**
  - `reqX_ready_o` = (state==IDLE) && grant==X.
  - Ready may depend combinationally on valid.
  - With no valid request, both readies are 0.
- **Round-robin grant:**
  - If only one port is valid, that port wins.
  - If both are valid, the port not named by `last_q` wins.
  - `last_q` resets to 1, so port 0 wins the first contention.
- **Accept** (valid && ready):
  - Latch `op_q`, `a_q`, `b_q` and `id_q`, and set `last_q` to the winner.
  - Load `cnt_q` with `MUL_LAT-1` if op is `ALU_MUL`, else 0.
  - Go to EXEC.
- **EXEC:**
  - The ALU is driven only from `op_q`, `a_q`, `b_q`.
  - If `cnt_q` != 0: decrement it and stay in EXEC.
  - If `cnt_q` == 0: capture the ALU output into `res_q` and go to RESP.
- **RESP:**
  - `rsp_valid_o` = 1.
  - `rsp_data_o`, `rsp_id_o` and `rsp_zero_o` are held stable until `rsp_ready_i`=1.
  - On a handshake, go to IDLE.
  - No new request is accepted in the handshake cycle. Throughput is at most one op per 3 cycles.
- **Arithmetic** follows the ALU semantics:
  - All results are 32-bit, truncated.
  - The shift amount is taken from the full `b_q`; amounts ≥32 give 0 for SLL and sign-fill for SRA.
  - Unused op codes give result 0.
- **Zero flag:** `rsp_zero_o` is computed from `res_q`. The ALU's own zero output is ignored.
- **Reset mid-operation:** asserting `rst_i` in EXEC or RESP drops the operation. The next cycle is IDLE with all outputs 0.
- **Stability:** requests not accepted must hold their payload while valid. The block does not check this.

## Timing
- **Output reset values:** all outputs 0, with `rsp_data_o`=32'h0 and `rsp_zero_o`=0. The zero flag is forced to 0 whenever `rsp_valid_o`=0.
- **Latency, non-MUL op:** accepted at edge k, EXEC during cycle k+1, `rsp_valid_o` high from cycle k+2.
- **Latency, MUL:** `rsp_valid_o` high from cycle k+1+`MUL_LAT`.
- **Back-pressure:** `rsp_ready_i` held low keeps RESP indefinitely, and both request readies stay 0.
- **Request valid while busy:** a valid request arriving during EXEC or RESP waits. Its ready goes high in the first IDLE cycle.

## Structure
- **Shared header:** the `ALU_*` op-code macros (already in the shared header) and the FSM state encodings `ARB_IDLE`, `ARB_EXEC`, `ARB_RESP`.
- **Sub-module `rr_arb2`:** the combinational two-way round-robin grant, with inputs `valid[1:0]` and `last`, and outputs `grant` and `any`.
- **Datapath:** one instance of the team's existing ALU, fed from the operand registers.
- **Size:** remaining RTL is the FSM, counter and registers, about 150–200 lines total.

## Test plan
- Port 0 requests ADD, a=5, b=7, `rsp_ready_i`=1 → `rsp_valid_o` 2 cycles after accept, data 12, id 0, zero 0.
- Both ports valid from reset, port 0 SUB 9−9 and port 1 XOR 3^5 → port 0 served first (data 0, zero 1), then port 1 (data 6, id 1). Repeat contention → port 0 again.
- Port 1 MUL 0xFFFF×0x10001 with `MUL_LAT`=3 → `rsp_valid_o` 4 cycles after accept, data 32'hFFFFFFFF, operands unchanged during EXEC.
- `rsp_ready_i` held 0 for 10 cycles in RESP → data and id stable, both request readies 0. Release → IDLE next cycle.
- Assert `rst_i` during MUL EXEC → outputs 0 immediately, no response issued; a new AND request afterwards completes normally.
- SRA with a=32'h80000000, b=40 → 32'hFFFFFFFF; unused op code 3'b111 → data 0, zero 1.
